// File: rtl/axil4_mmio_slave.sv
`timescale 1ns/1ps
// AXI-Lite responder over a DEPTH x 128b register line store with byte-strobed writes and
// programmable read/write latency; out-of-window reads return zero, out-of-window writes SLVERR.
module axil4_mmio_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          DEPTH     = 16,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  readAddr_addr,
    input  logic         readAddr_valid,
    output logic         readAddr_ready,
    output logic [127:0] readData_data,
    output logic         readData_valid,
    input  logic         readData_ready,
    input  logic [31:0]  writeAddr_addr,
    input  logic         writeAddr_valid,
    output logic         writeAddr_ready,
    input  logic [127:0] writeData_data,
    input  logic [15:0]  writeData_strb,
    input  logic         writeData_valid,
    output logic         writeData_ready,
    output logic [31:0]  writeResp_msg,
    output logic         writeResp_valid,
    input  logic         writeResp_ready
);
    localparam int          IDXW    = $clog2(DEPTH);
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(DEPTH * 16);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    // Full 32-bit compare; the extra top bit keeps a window ending at 4 GiB from wrapping.
    function automatic logic in_win(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < WIN_END);
    endfunction

    rd_state_t       rd_state_q, rd_state_d;
    logic [3:0]      rd_cnt_q, rd_cnt_d;
    logic [31:0]     rd_addr_q, rd_addr_d;
    logic            rd_ardy_q, rd_ardy_d;
    logic            rd_dvld_q, rd_dvld_d;
    logic [127:0]    rd_data_q, rd_data_d;

    wr_state_t       wr_state_q, wr_state_d;
    logic [3:0]      wr_cnt_q, wr_cnt_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [127:0]    wr_data_q, wr_data_d;
    logic [15:0]     wr_strb_q, wr_strb_d;
    logic            aw_got_q, aw_got_d;
    logic            w_got_q, w_got_d;
    logic            aw_rdy_q, aw_rdy_d;
    logic            w_rdy_q, w_rdy_d;
    logic            resp_vld_q, resp_vld_d;
    logic [31:0]     resp_msg_q, resp_msg_d;

    logic [127:0]    store_q [DEPTH];
    logic [127:0]    store_d [DEPTH];
    logic            commit;
    logic [IDXW-1:0] rd_idx, wr_idx;

    assign rd_idx = rd_addr_q[IDXW+3:4];
    assign wr_idx = wr_addr_q[IDXW+3:4];

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_dvld_d  = rd_dvld_q;
        rd_data_d  = rd_data_q;
        case (rd_state_q)
            R_IDLE: if (readAddr_valid && rd_ardy_q) begin
                rd_addr_d  = readAddr_addr;
                rd_cnt_d   = 4'(RD_LAT);
                rd_state_d = R_WAIT;
            end
            R_WAIT: if (rd_cnt_q == 4'd0) begin
                // Samples the registered store, so a same-edge write commit is not yet visible.
                rd_data_d  = in_win(rd_addr_q) ? store_q[rd_idx] : 128'h0;
                rd_dvld_d  = 1'b1;
                rd_state_d = R_RESP;
            end else begin
                rd_cnt_d = rd_cnt_q - 4'd1;
            end
            R_RESP: if (readData_ready) begin
                rd_dvld_d  = 1'b0;
                rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
        rd_ardy_d = (rd_state_d == R_IDLE);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        resp_vld_d = resp_vld_q;
        resp_msg_d = resp_msg_q;
        commit     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (writeAddr_valid && aw_rdy_q) begin
                    wr_addr_d = writeAddr_addr;
                    aw_got_d  = 1'b1;
                end
                if (writeData_valid && w_rdy_q) begin
                    wr_data_d = writeData_data;
                    wr_strb_d = writeData_strb;
                    w_got_d   = 1'b1;
                end
                if (aw_got_d && w_got_d) begin
                    wr_cnt_d   = 4'(WR_LAT);
                    wr_state_d = W_WAIT;
                end
            end
            W_WAIT: if (wr_cnt_q == 4'd0) begin
                commit     = 1'b1;
                resp_msg_d = in_win(wr_addr_q) ? 32'h0 : 32'h2;
                resp_vld_d = 1'b1;
                wr_state_d = W_RESP;
            end else begin
                wr_cnt_d = wr_cnt_q - 4'd1;
            end
            W_RESP: if (writeResp_ready) begin
                resp_vld_d = 1'b0;
                aw_got_d   = 1'b0;
                w_got_d    = 1'b0;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        aw_rdy_d = (wr_state_d == W_IDLE) && !aw_got_d;
        w_rdy_d  = (wr_state_d == W_IDLE) && !w_got_d;
    end

    always_comb begin
        store_d = store_q;
        if (commit && in_win(wr_addr_q)) begin
            for (int b = 0; b < 16; b++) begin
                if (wr_strb_q[b]) store_d[wr_idx][8*b +: 8] = wr_data_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_addr_q  <= '0;
            rd_ardy_q  <= 1'b0;
            rd_dvld_q  <= 1'b0;
            rd_data_q  <= '0;
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            aw_rdy_q   <= 1'b0;
            w_rdy_q    <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_msg_q <= '0;
            for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_ardy_q  <= rd_ardy_d;
            rd_dvld_q  <= rd_dvld_d;
            rd_data_q  <= rd_data_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            aw_rdy_q   <= aw_rdy_d;
            w_rdy_q    <= w_rdy_d;
            resp_vld_q <= resp_vld_d;
            resp_msg_q <= resp_msg_d;
            for (int i = 0; i < DEPTH; i++) store_q[i] <= store_d[i];
        end
    end

    assign readAddr_ready  = rd_ardy_q;
    assign readData_valid  = rd_dvld_q;
    assign readData_data   = rd_data_q;
    assign writeAddr_ready = aw_rdy_q;
    assign writeData_ready = w_rdy_q;
    assign writeResp_valid = resp_vld_q;
    assign writeResp_msg   = resp_msg_q;
endmodule

// File: tb/tb_axil4_mmio_slave.sv
`timescale 1ns/1ps
// Directed bench for axil4_mmio_slave: reset, strobed writes, channel ordering, window errors,
// backpressure, mid-transaction reset and same-edge read/write collision.
module tb_axil4_mmio_slave;
    localparam int TMO = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid;
    logic         readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid;
    logic         readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid;
    logic         writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready;

    int checks = 0;
    int passes = 0;

    localparam logic [127:0] D2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] E2 = 128'h00000000_00000000_8899AABB_00000000;
    localparam logic [127:0] DX = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] DY = 128'hA5A55A5A_C3C33C3C_0F0FF0F0_12345678;
    localparam logic [127:0] W1 = {8{16'h1111}};
    localparam logic [127:0] WZ = {8{16'h2222}};

    always #5 clk = ~clk;

    axil4_mmio_slave #(
        .BASE_ADDR(32'h0000_8000), .DEPTH(16), .RD_LAT(2), .WR_LAT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid),
        .readAddr_ready(readAddr_ready),
        .readData_data(readData_data), .readData_valid(readData_valid),
        .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid),
        .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb),
        .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid),
        .writeResp_ready(writeResp_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d,
                           output int lat, output bit ok);
        int n;
        n = 0;
        readAddr_addr  = a;
        readAddr_valid = 1'b1;
        while (readAddr_ready !== 1'b1 && n < TMO) begin step(); n++; end
        step();
        readAddr_valid = 1'b0;
        lat = 0;
        while (readData_valid !== 1'b1 && lat < TMO) begin step(); lat++; end
        d = readData_data;
        readData_ready = 1'b1;
        step();
        readData_ready = 1'b0;
        ok = (n < TMO) && (lat < TMO);
    endtask

    // mode 0: both channels together, 1: data first, 2: address first
    task automatic do_write(input logic [31:0] a, input logic [127:0] dat,
                            input logic [15:0] strb, input int mode,
                            output logic [31:0] msg, output int lat,
                            output logic [1:0] mid, output bit ok);
        int n;
        n = 0;
        while ((writeAddr_ready & writeData_ready) !== 1'b1 && n < TMO) begin step(); n++; end
        writeAddr_addr = a;
        writeData_data = dat;
        writeData_strb = strb;
        mid = 2'b00;
        if (mode == 0) begin
            writeAddr_valid = 1'b1; writeData_valid = 1'b1;
            step();
            writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        end else if (mode == 1) begin
            writeData_valid = 1'b1;
            step();
            writeData_valid = 1'b0;
            mid = {writeAddr_ready, writeData_ready};
            writeAddr_valid = 1'b1;
            step();
            writeAddr_valid = 1'b0;
        end else begin
            writeAddr_valid = 1'b1;
            step();
            writeAddr_valid = 1'b0;
            mid = {writeAddr_ready, writeData_ready};
            writeData_valid = 1'b1;
            step();
            writeData_valid = 1'b0;
        end
        lat = 0;
        while (writeResp_valid !== 1'b1 && lat < TMO) begin step(); lat++; end
        msg = writeResp_msg;
        writeResp_ready = 1'b1;
        step();
        writeResp_ready = 1'b0;
        ok = (n < TMO) && (lat < TMO);
    endtask

    task automatic test_reset();
        logic [127:0] d;
        int lat;
        bit ok;
        rst = 1'b0;
        readAddr_addr = '0; readAddr_valid = 1'b0; readData_ready = 1'b0;
        writeAddr_addr = '0; writeAddr_valid = 1'b0;
        writeData_data = '0; writeData_strb = '0; writeData_valid = 1'b0;
        writeResp_ready = 1'b0;
        repeat (3) step();
        checks++;
        if ({readAddr_ready, writeAddr_ready, writeData_ready, readData_valid, writeResp_valid} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {readAddr_ready, writeAddr_ready, writeData_ready, readData_valid, writeResp_valid});
        else passes++;
        checks++;
        if ({readData_data, writeResp_msg} !== 160'h0)
            $display("FAIL reset_data: got %h/%h want 0", readData_data, writeResp_msg);
        else passes++;
        rst = 1'b1;
        step();
        checks++;
        if ({readAddr_ready, writeAddr_ready, writeData_ready} !== 3'b111)
            $display("FAIL ready_after_reset: got %b want 111",
                     {readAddr_ready, writeAddr_ready, writeData_ready});
        else passes++;
        do_read(32'h0000_8010, d, lat, ok);
        checks++;
        if (!ok || lat !== 3) $display("FAIL first_read_latency: got %0d want 3", lat);
        else passes++;
        checks++;
        if (d !== 128'h0) $display("FAIL first_read_data: got %h want 0", d);
        else passes++;
    endtask

    task automatic test_strobe_write();
        logic [127:0] d;
        logic [31:0] msg;
        logic [1:0] mid;
        int lat;
        bit ok;
        do_write(32'h0000_8020, D2, 16'h00F0, 0, msg, lat, mid, ok);
        checks++;
        if (!ok || msg !== 32'h0 || lat !== 3)
            $display("FAIL strb_write_resp: got msg %h lat %0d want 0 lat 3", msg, lat);
        else passes++;
        do_read(32'h0000_8020, d, lat, ok);
        checks++;
        if (!ok || d !== E2) $display("FAIL strb_readback: got %h want %h", d, E2);
        else passes++;
    endtask

    task automatic test_write_order();
        logic [127:0] d;
        logic [31:0] msg;
        logic [1:0] mid;
        int lat;
        bit ok;
        do_write(32'h0000_8030, DX, 16'hFFFF, 1, msg, lat, mid, ok);
        checks++;
        if (mid !== 2'b10) $display("FAIL data_first_readys: got %b want 10", mid);
        else passes++;
        checks++;
        if (!ok || msg !== 32'h0 || lat !== 3)
            $display("FAIL data_first_resp: got msg %h lat %0d want 0 lat 3", msg, lat);
        else passes++;
        do_write(32'h0000_8040, DY, 16'hFFFF, 2, msg, lat, mid, ok);
        checks++;
        if (mid !== 2'b01) $display("FAIL addr_first_readys: got %b want 01", mid);
        else passes++;
        checks++;
        if (!ok || msg !== 32'h0 || lat !== 3)
            $display("FAIL addr_first_resp: got msg %h lat %0d want 0 lat 3", msg, lat);
        else passes++;
        repeat (3) step();
        checks++;
        if (writeResp_valid !== 1'b0) $display("FAIL single_resp: got %b want 0", writeResp_valid);
        else passes++;
        do_read(32'h0000_8030, d, lat, ok);
        checks++;
        if (!ok || d !== DX) $display("FAIL data_first_readback: got %h want %h", d, DX);
        else passes++;
        do_read(32'h0000_8040, d, lat, ok);
        checks++;
        if (!ok || d !== DY) $display("FAIL addr_first_readback: got %h want %h", d, DY);
        else passes++;
    endtask

    task automatic test_out_of_window();
        logic [127:0] d;
        logic [31:0] msg;
        logic [1:0] mid;
        int lat;
        bit ok;
        do_read(32'h0000_0040, d, lat, ok);
        checks++;
        if (!ok || d !== 128'h0 || lat !== 3)
            $display("FAIL oow_read: got %h lat %0d want 0 lat 3", d, lat);
        else passes++;
        do_write(32'h0000_9000, {128{1'b1}}, 16'hFFFF, 0, msg, lat, mid, ok);
        checks++;
        if (!ok || msg !== 32'h2) $display("FAIL oow_write_msg: got %h want 2", msg);
        else passes++;
        do_read(32'h0000_8000, d, lat, ok);
        checks++;
        if (!ok || d !== 128'h0) $display("FAIL oow_store_line0: got %h want 0", d);
        else passes++;
        do_read(32'h0000_8020, d, lat, ok);
        checks++;
        if (!ok || d !== E2) $display("FAIL oow_store_line2: got %h want %h", d, E2);
        else passes++;
    endtask

    task automatic test_backpressure_reset();
        logic [127:0] d;
        int lat;
        int n;
        bit ok;
        n = 0;
        readAddr_addr = 32'h0000_8030;
        readAddr_valid = 1'b1;
        while (readAddr_ready !== 1'b1 && n < TMO) begin step(); n++; end
        step();
        readAddr_valid = 1'b0;
        while (readData_valid !== 1'b1 && n < TMO) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({readData_valid, readAddr_ready} !== 2'b10 || readData_data !== DX)
                $display("FAIL hold_stable[%0d]: got v/r %b data %h want 10 %h",
                         i, {readData_valid, readAddr_ready}, readData_data, DX);
            else passes++;
            step();
        end
        readData_ready = 1'b1;
        step();
        readData_ready = 1'b0;
        checks++;
        if (readData_valid !== 1'b0) $display("FAIL hold_release: got %b want 0", readData_valid);
        else passes++;
        readAddr_valid = 1'b1;
        step();
        readAddr_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({readAddr_ready, writeAddr_ready, writeData_ready, readData_valid, writeResp_valid} !== 5'b0
            || readData_data !== 128'h0)
            $display("FAIL mid_reset_outputs: got %b data %h want 00000 0",
                     {readAddr_ready, writeAddr_ready, writeData_ready, readData_valid, writeResp_valid},
                     readData_data);
        else passes++;
        step();
        rst = 1'b1;
        repeat (5) step();
        checks++;
        if (readData_valid !== 1'b0) $display("FAIL dropped_read: got %b want 0", readData_valid);
        else passes++;
        do_read(32'h0000_8030, d, lat, ok);
        checks++;
        if (!ok || d !== 128'h0) $display("FAIL store_cleared: got %h want 0", d);
        else passes++;
    endtask

    task automatic test_collision();
        logic [127:0] d;
        logic [31:0] msg;
        logic [1:0] mid;
        int lat;
        int n;
        bit ok;
        do_write(32'h0000_8030, W1, 16'hFFFF, 0, msg, lat, mid, ok);
        n = 0;
        while ((readAddr_ready & writeAddr_ready & writeData_ready) !== 1'b1 && n < TMO) begin
            step(); n++;
        end
        readAddr_addr = 32'h0000_8030;
        writeAddr_addr = 32'h0000_8030;
        writeData_data = WZ;
        writeData_strb = 16'hFFFF;
        readAddr_valid = 1'b1; writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        step();
        readAddr_valid = 1'b0; writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        repeat (2) step();
        checks++;
        if ({readData_valid, writeResp_valid} !== 2'b00)
            $display("FAIL collide_early: got %b want 00", {readData_valid, writeResp_valid});
        else passes++;
        step();
        checks++;
        if ({readData_valid, writeResp_valid} !== 2'b11 || writeResp_msg !== 32'h0)
            $display("FAIL collide_valids: got %b msg %h want 11 0",
                     {readData_valid, writeResp_valid}, writeResp_msg);
        else passes++;
        checks++;
        if (readData_data !== W1) $display("FAIL collide_old_data: got %h want %h", readData_data, W1);
        else passes++;
        readData_ready = 1'b1; writeResp_ready = 1'b1;
        step();
        readData_ready = 1'b0; writeResp_ready = 1'b0;
        do_read(32'h0000_8030, d, lat, ok);
        checks++;
        if (!ok || d !== WZ) $display("FAIL collide_reread: got %h want %h", d, WZ);
        else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_strobe_write();
        test_write_order();
        test_out_of_window();
        test_backpressure_reset();
        test_collision();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
